// File: rtl/core_pkg.sv
// Shared definitions for the 5-stage MIPS core pipeline.
// Contents:
//   aluop_t  - decoder ALUOp encodings (memory, branch, R-type).
//   brtype_t - branch condition select (beq / bne).
//   ctrl_t   - control bundle carried from ID into EX.
//   CTRL_NOP - all-zero control bundle used for pipeline bubbles.
package core_pkg;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10
  } aluop_t;

  typedef enum logic {
    BRTYPE_BEQ = 1'b0,
    BRTYPE_BNE = 1'b1
  } brtype_t;

  typedef struct packed {
    logic    valid;
    aluop_t  aluop;
    logic    alusrc;
    logic    regwrite;
    logic    regdst;
    logic    branch;
    logic    memread;
    logic    memwrite;
    logic    memtoreg;
    brtype_t brtype;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    valid:    1'b0,
    aluop:    ALUOP_MEM,
    alusrc:   1'b0,
    regwrite: 1'b0,
    regdst:   1'b0,
    branch:   1'b0,
    memread:  1'b0,
    memwrite: 1'b0,
    memtoreg: 1'b0,
    brtype:   BRTYPE_BEQ
  };

endpackage

// File: rtl/hazard_unit.sv
// Load-use hazard detection for the ID/EX boundary (purely combinational).
// Ports:
//   ex_valid, ex_memread, ex_rt        - instruction currently in EX
//   id_valid, id_alusrc, id_memwrite,
//   id_rs, id_rt                       - instruction currently in ID
//   flush                              - branch redirect in progress
//   stall                              - insert bubble, freeze PC and IF/ID
//   pc_write, if_id_write              - front-end enables (low on stall)
module hazard_unit (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       id_valid,
  input  logic       id_alusrc,
  input  logic       id_memwrite,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       flush,
  output logic       stall,
  output logic       pc_write,
  output logic       if_id_write
);

  logic id_reads_rs;
  logic id_reads_rt;
  logic hazard;

  always_comb begin
    // Only R-type, branches and stores source rt; immediate ALU ops and loads do not.
    id_reads_rs = id_valid;
    id_reads_rt = id_valid & (~id_alusrc | id_memwrite);
    // Register 0 is hardwired, so a load into it can never create a dependency.
    hazard      = ex_valid & ex_memread & (ex_rt != 5'd0) &
                  ((id_reads_rs & (ex_rt == id_rs)) |
                   (id_reads_rt & (ex_rt == id_rt)));
    // A flush kills the dependent instruction anyway, so it overrides the stall.
    stall       = hazard & ~flush;
    pc_write    = ~stall;
    if_id_write = ~stall;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with embedded load-use stall and branch flush.
// Ports:
//   clk_i, rst_i (async, active-low)
//   id_*_i        - decoder control bundle, register specifiers, operands,
//                   immediate, funct and PC+4 from the ID stage
//   flush_i       - branch taken; kill the instruction in ID
//   ex_*_o        - registered EX bundle (1-cycle latency)
//   pc_write_o    - PC update enable (combinational)
//   if_id_write_o - IF/ID register enable (combinational)
//   stall_cnt_o   - saturating count of load-use stalls
//   flush_cnt_o   - saturating count of flushes
module id_ex_stage
  import core_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [1:0]        id_aluop_i,
  input  logic              id_alusrc_i,
  input  logic              id_regwrite_i,
  input  logic              id_regdst_i,
  input  logic              id_branch_i,
  input  logic              id_memread_i,
  input  logic              id_memwrite_i,
  input  logic              id_memtoreg_i,
  input  logic              id_brtype_i,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic [4:0]        id_rd_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [5:0]        id_funct_i,
  input  logic [DATA_W-1:0] id_pc4_i,
  input  logic              flush_i,
  output logic              ex_valid_o,
  output logic [1:0]        ex_aluop_o,
  output logic              ex_alusrc_o,
  output logic              ex_regwrite_o,
  output logic              ex_regdst_o,
  output logic              ex_branch_o,
  output logic              ex_memread_o,
  output logic              ex_memwrite_o,
  output logic              ex_memtoreg_o,
  output logic              ex_brtype_o,
  output logic [4:0]        ex_rs_o,
  output logic [4:0]        ex_rt_o,
  output logic [4:0]        ex_rd_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [5:0]        ex_funct_o,
  output logic [DATA_W-1:0] ex_pc4_o,
  output logic              pc_write_o,
  output logic              if_id_write_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  ctrl_t              id_ctrl;
  ctrl_t              ex_ctrl;
  logic               stall;
  logic               bubble;
  logic [4:0]         ex_rs, ex_rt, ex_rd;
  logic [DATA_W-1:0]  ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
  logic [5:0]         ex_funct;
  logic [CNT_W-1:0]   stall_cnt, flush_cnt;

  hazard_unit u_hazard (
    .ex_valid    (ex_ctrl.valid),
    .ex_memread  (ex_ctrl.memread),
    .ex_rt       (ex_rt),
    .id_valid    (id_valid_i),
    .id_alusrc   (id_alusrc_i),
    .id_memwrite (id_memwrite_i),
    .id_rs       (id_rs_i),
    .id_rt       (id_rt_i),
    .flush       (flush_i),
    .stall       (stall),
    .pc_write    (pc_write_o),
    .if_id_write (if_id_write_o)
  );

  // An invalid ID slot contributes no side effects, whatever the decoder drives.
  always_comb begin
    id_ctrl = CTRL_NOP;
    if (id_valid_i) begin
      id_ctrl.valid    = 1'b1;
      id_ctrl.aluop    = aluop_t'(id_aluop_i);
      id_ctrl.alusrc   = id_alusrc_i;
      id_ctrl.regwrite = id_regwrite_i;
      id_ctrl.regdst   = id_regdst_i;
      id_ctrl.branch   = id_branch_i;
      id_ctrl.memread  = id_memread_i;
      id_ctrl.memwrite = id_memwrite_i;
      id_ctrl.memtoreg = id_memtoreg_i;
      id_ctrl.brtype   = brtype_t'(id_brtype_i);
    end
  end

  assign bubble = stall | flush_i;

  // Bubbles clear only the control bundle; data fields hold their previous values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_ctrl    <= CTRL_NOP;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_funct   <= '0;
      ex_pc4     <= '0;
    end else if (bubble) begin
      ex_ctrl    <= CTRL_NOP;
    end else begin
      ex_ctrl    <= id_ctrl;
      ex_rs      <= id_rs_i;
      ex_rt      <= id_rt_i;
      ex_rd      <= id_rd_i;
      ex_rs_data <= id_rs_data_i;
      ex_rt_data <= id_rt_data_i;
      ex_imm     <= id_imm_i;
      ex_funct   <= id_funct_i;
      ex_pc4     <= id_pc4_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_i && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign ex_valid_o    = ex_ctrl.valid;
  assign ex_aluop_o    = ex_ctrl.aluop;
  assign ex_alusrc_o   = ex_ctrl.alusrc;
  assign ex_regwrite_o = ex_ctrl.regwrite;
  assign ex_regdst_o   = ex_ctrl.regdst;
  assign ex_branch_o   = ex_ctrl.branch;
  assign ex_memread_o  = ex_ctrl.memread;
  assign ex_memwrite_o = ex_ctrl.memwrite;
  assign ex_memtoreg_o = ex_ctrl.memtoreg;
  assign ex_brtype_o   = ex_ctrl.brtype;
  assign ex_rs_o       = ex_rs;
  assign ex_rt_o       = ex_rt;
  assign ex_rd_o       = ex_rd;
  assign ex_rs_data_o  = ex_rs_data;
  assign ex_rt_data_o  = ex_rt_data;
  assign ex_imm_o      = ex_imm;
  assign ex_funct_o    = ex_funct;
  assign ex_pc4_o      = ex_pc4;
  assign stall_cnt_o   = stall_cnt;
  assign flush_cnt_o   = flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage (CNT_W=2 so counter saturation is reachable).
module tb_id_ex_stage;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              id_valid_i;
  logic [1:0]        id_aluop_i;
  logic              id_alusrc_i, id_regwrite_i, id_regdst_i, id_branch_i;
  logic              id_memread_i, id_memwrite_i, id_memtoreg_i, id_brtype_i;
  logic [4:0]        id_rs_i, id_rt_i, id_rd_i;
  logic [DATA_W-1:0] id_rs_data_i, id_rt_data_i, id_imm_i, id_pc4_i;
  logic [5:0]        id_funct_i;
  logic              flush_i;
  logic              ex_valid_o;
  logic [1:0]        ex_aluop_o;
  logic              ex_alusrc_o, ex_regwrite_o, ex_regdst_o, ex_branch_o;
  logic              ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_brtype_o;
  logic [4:0]        ex_rs_o, ex_rt_o, ex_rd_o;
  logic [DATA_W-1:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, ex_pc4_o;
  logic [5:0]        ex_funct_o;
  logic              pc_write_o, if_id_write_o;
  logic [CNT_W-1:0]  stall_cnt_o, flush_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .id_valid_i(id_valid_i), .id_aluop_i(id_aluop_i), .id_alusrc_i(id_alusrc_i),
    .id_regwrite_i(id_regwrite_i), .id_regdst_i(id_regdst_i), .id_branch_i(id_branch_i),
    .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i),
    .id_brtype_i(id_brtype_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_funct_i(id_funct_i), .id_pc4_i(id_pc4_i), .flush_i(flush_i),
    .ex_valid_o(ex_valid_o), .ex_aluop_o(ex_aluop_o), .ex_alusrc_o(ex_alusrc_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_regdst_o(ex_regdst_o), .ex_branch_o(ex_branch_o),
    .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o), .ex_memtoreg_o(ex_memtoreg_o),
    .ex_brtype_o(ex_brtype_o), .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_funct_o(ex_funct_o), .ex_pc4_o(ex_pc4_o),
    .pc_write_o(pc_write_o), .if_id_write_o(if_id_write_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] aluop, input logic alusrc,
                       input logic regwrite, input logic regdst, input logic memread,
                       input logic memwrite, input logic memtoreg,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    id_valid_i    = v;
    id_aluop_i    = aluop;
    id_alusrc_i   = alusrc;
    id_regwrite_i = regwrite;
    id_regdst_i   = regdst;
    id_branch_i   = 1'b0;
    id_memread_i  = memread;
    id_memwrite_i = memwrite;
    id_memtoreg_i = memtoreg;
    id_brtype_i   = 1'b0;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_rd_i       = rd;
    id_rs_data_i  = 32'h1000 + 32'(rs);
    id_rt_data_i  = 32'h2000 + 32'(rt);
    id_imm_i      = 32'h0000_1234;
    id_funct_i    = 6'h20;
    id_pc4_i      = 32'h0040_0004;
  endtask

  task automatic drive_nop();           drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0); endtask
  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, rs, rt, 5'd0);
  endtask
  task automatic drive_addi(input logic [4:0] rs, input logic [4:0] rt);
    drive(1'b1, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rs, rt, 5'd0);
  endtask
  task automatic drive_r(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    drive(1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rs, rt, rd);
  endtask

  initial begin
    // Reset held while inputs toggle, including flush.
    rst_i   = 1'b0;
    flush_i = 1'b1;
    drive_lw(5'd1, 5'd8);
    step();
    drive_r(5'd8, 5'd2, 5'd9);
    step();
    check("rst_ex_valid",  64'(ex_valid_o), 64'd0);
    check("rst_regwrite",  64'(ex_regwrite_o), 64'd0);
    check("rst_ex_rt",     64'(ex_rt_o), 64'd0);
    check("rst_ex_imm",    64'(ex_imm_o), 64'd0);
    check("rst_stall_cnt", 64'(stall_cnt_o), 64'd0);
    check("rst_flush_cnt", 64'(flush_cnt_o), 64'd0);
    check("rst_pc_write",  64'(pc_write_o), 64'd1);
    check("rst_if_id_wr",  64'(if_id_write_o), 64'd1);

    // Release, addi rt=5 registers one edge later.
    rst_i   = 1'b1;
    flush_i = 1'b0;
    drive_addi(5'd3, 5'd5);
    step();
    check("addi_valid",    64'(ex_valid_o), 64'd1);
    check("addi_regwrite", 64'(ex_regwrite_o), 64'd1);
    check("addi_rt",       64'(ex_rt_o), 64'd5);
    check("addi_alusrc",   64'(ex_alusrc_o), 64'd1);
    check("addi_imm",      64'(ex_imm_o), 64'h1234);
    check("addi_rs_data",  64'(ex_rs_data_o), 64'h1003);

    // Load-use on rs.
    drive_lw(5'd1, 5'd8);
    step();
    check("lw_memread", 64'(ex_memread_o), 64'd1);
    drive_r(5'd8, 5'd2, 5'd9);
    #1;
    check("lu_pc_write",    64'(pc_write_o), 64'd0);
    check("lu_if_id_write", 64'(if_id_write_o), 64'd0);
    step();
    check("lu_bubble_valid",    64'(ex_valid_o), 64'd0);
    check("lu_bubble_regwrite", 64'(ex_regwrite_o), 64'd0);
    check("lu_bubble_memread",  64'(ex_memread_o), 64'd0);
    check("lu_stall_cnt",       64'(stall_cnt_o), 64'd1);
    check("lu_released",        64'(pc_write_o), 64'd1);
    step();
    check("lu_r_valid",  64'(ex_valid_o), 64'd1);
    check("lu_r_rd",     64'(ex_rd_o), 64'd9);
    check("lu_r_regdst", 64'(ex_regdst_o), 64'd1);
    check("lu_r_aluop",  64'(ex_aluop_o), 64'd2);

    // addi reading rs=3 with rt=8 as destination: no dependency.
    drive_lw(5'd1, 5'd8);
    step();
    drive_addi(5'd3, 5'd8);
    #1;
    check("nf_addi_pc_write", 64'(pc_write_o), 64'd1);
    step();
    check("nf_addi_valid", 64'(ex_valid_o), 64'd1);
    check("nf_addi_rt",    64'(ex_rt_o), 64'd8);
    check("nf_addi_cnt",   64'(stall_cnt_o), 64'd1);

    // Load into r0 never stalls.
    drive_lw(5'd1, 5'd0);
    step();
    drive_r(5'd0, 5'd0, 5'd4);
    #1;
    check("nf_r0_pc_write", 64'(pc_write_o), 64'd1);
    step();
    check("nf_r0_rd",  64'(ex_rd_o), 64'd4);
    check("nf_r0_cnt", 64'(stall_cnt_o), 64'd1);

    // Flush wins over a simultaneous hazard.
    drive_lw(5'd1, 5'd8);
    step();
    drive_r(5'd8, 5'd2, 5'd9);
    flush_i = 1'b1;
    #1;
    check("fl_pc_write",    64'(pc_write_o), 64'd1);
    check("fl_if_id_write", 64'(if_id_write_o), 64'd1);
    step();
    flush_i = 1'b0;
    drive_nop();
    check("fl_bubble_valid", 64'(ex_valid_o), 64'd0);
    check("fl_bubble_rw",    64'(ex_regwrite_o), 64'd0);
    check("fl_flush_cnt",    64'(flush_cnt_o), 64'd1);
    check("fl_stall_cnt",    64'(stall_cnt_o), 64'd1);

    // Back-to-back loads, second depends on first (rs), R-type depends on second (rt).
    drive_lw(5'd1, 5'd8);
    step();
    drive_lw(5'd8, 5'd9);
    #1;
    check("b2b_stall1", 64'(pc_write_o), 64'd0);
    step();
    check("b2b_cnt2",   64'(stall_cnt_o), 64'd2);
    check("b2b_clear1", 64'(pc_write_o), 64'd1);
    step();
    check("b2b_lw2_rt", 64'(ex_rt_o), 64'd9);
    drive_r(5'd2, 5'd9, 5'd10);
    #1;
    check("b2b_stall2_rt", 64'(pc_write_o), 64'd0);
    step();
    check("b2b_cnt3", 64'(stall_cnt_o), 64'd3);
    step();
    check("b2b_r_rd", 64'(ex_rd_o), 64'd10);

    // One more stall: counter stays saturated at 3.
    drive_lw(5'd1, 5'd8);
    step();
    drive_r(5'd8, 5'd2, 5'd11);
    step();
    check("stall_sat", 64'(stall_cnt_o), 64'd3);
    step();

    // Four more flushes (five total): flush counter sticks at 3.
    drive_nop();
    flush_i = 1'b1;
    step();
    step();
    check("flush_cnt3", 64'(flush_cnt_o), 64'd3);
    step();
    step();
    flush_i = 1'b0;
    check("flush_sat", 64'(flush_cnt_o), 64'd3);

    // Async reset asserted between edges during a stall.
    drive_lw(5'd1, 5'd8);
    step();
    drive_r(5'd8, 5'd2, 5'd9);
    #1;
    check("ar_stalling", 64'(pc_write_o), 64'd0);
    #1;
    rst_i = 1'b0;
    #1;
    check("ar_valid",     64'(ex_valid_o), 64'd0);
    check("ar_memread",   64'(ex_memread_o), 64'd0);
    check("ar_rt",        64'(ex_rt_o), 64'd0);
    check("ar_stall_cnt", 64'(stall_cnt_o), 64'd0);
    check("ar_flush_cnt", 64'(flush_cnt_o), 64'd0);
    check("ar_pc_write",  64'(pc_write_o), 64'd1);
    step();
    rst_i = 1'b1;
    drive_addi(5'd3, 5'd5);
    step();
    check("post_rst_valid", 64'(ex_valid_o), 64'd1);
    check("post_rst_rt",    64'(ex_rt_o), 64'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
